multicycle_sequencer: RTL

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer_pkg.sv | 30 +++
 rtl/multicycle_sequencer_bus_timer.sv | 37 +++
 rtl/multicycle_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encodings, trap causes and decoder control bundle
// for the multicycle sequencer.
package multicycle_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    typedef struct packed {
        logic mem_w;
        logic reg_w;
        logic mem2reg;
        logic bra;
        logic jmp;
    } ctrl_t;

    function automatic logic needs_mem(ctrl_t c);
        return c.mem_w | c.mem2reg;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_bus_timer.sv
// Bus wait counter: counts stalled request cycles and flags the
// last permitted cycle before a timeout trap.
module multicycle_sequencer_bus_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: fetch/decode/exec/mem/wb FSM
// with bus timeouts, trap handling and a retired-instruction counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_run,
    input  logic        i_trap_clr,
    input  logic        i_ctrl_valid,
    input  logic        i_mem_w,
    input  logic        i_reg_w,
    input  logic        i_mem2reg,
    input  logic        i_bra,
    input  logic        i_jmp,
    input  logic        i_br_taken,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    input  logic        i_dmem_ack,
    output logic        o_ir_we,
    output logic        o_mdr_we,
    output logic        o_rf_we,
    output logic        o_pc_we,
    output logic        o_pc_sel_tgt,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output logic [31:0] o_instret,
    output logic [2:0]  o_state
);

    logic [2:0]  state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        expired;
    logic        tmr_clr;
    logic        tmr_en;
    ctrl_t       ctrl;

    assign ctrl = '{mem_w: i_mem_w, reg_w: i_reg_w, mem2reg: i_mem2reg,
                    bra: i_bra, jmp: i_jmp};

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        o_imem_req   = 1'b0;
        o_ir_we      = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_mdr_we     = 1'b0;
        o_rf_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_pc_sel_tgt = 1'b0;
        o_trap       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    o_ir_we = 1'b1;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM;
                end
            end
            ST_DECODE: begin
                if (!i_ctrl_valid) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (needs_mem(ctrl)) state_d = ST_MEM;
                else if (ctrl.reg_w) state_d = ST_WB;
                else retire = 1'b1;
            end
            ST_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = ctrl.mem_w;
                if (i_dmem_ack) begin
                    if (ctrl.mem2reg) begin
                        o_mdr_we = 1'b1;
                        state_d  = ST_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM;
                end
            end
            ST_WB: begin
                o_rf_we = 1'b1;
                retire  = 1'b1;
            end
            ST_TRAP: begin
                o_trap = 1'b1;
                if (i_trap_clr) begin
                    cause_d = CAUSE_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Retire overrides the per-state next state and redirects the PC.
        if (retire) begin
            o_pc_we      = 1'b1;
            o_pc_sel_tgt = ctrl.jmp | (ctrl.bra & i_br_taken);
            state_d      = i_run ? ST_FETCH : ST_IDLE;
        end
    end

    assign instret_d = instret_q + {31'd0, retire};

    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = ((state_q == ST_FETCH) & ~i_imem_ack)
                   | ((state_q == ST_MEM) & ~i_dmem_ack);

    multicycle_sequencer_bus_timer #(
        .LIMIT(TIMEOUT)
    ) u_bus_timer (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clr    (tmr_clr),
        .i_en     (tmr_en),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign o_trap_cause = cause_q;
    assign o_instret    = instret_q;
    assign o_state      = state_q;

endmodule
